// File: rtl/bus_arb.sv
// rtl/bus_arb.sv - two-master (IF/MEM) single-slave bus arbiter, MEM priority, fetch flush drain
// Optional slave wait timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        stallreq_if_o,
  input  logic        flush_if_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stallreq_mem_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_IF_XFER  = 2'd1;
  localparam logic [1:0] S_MEM_XFER = 2'd2;
  localparam logic [1:0] S_IF_DRAIN = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        w_load_mem;
  logic        w_load_if;
  logic        w_timeout;
  logic        w_done;
  logic        w_if_data;
  logic        w_mem_data;

  assign w_done = bus_ack_i | w_timeout;

  always_comb begin
    w_next     = r_state;
    w_load_mem = 1'b0;
    w_load_if  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_load_mem = 1'b1;
          w_next     = S_MEM_XFER;
        end else if (if_req_i && !flush_if_i) begin
          w_load_if = 1'b1;
          w_next    = S_IF_XFER;
        end
      end
      S_IF_XFER: begin
        // A pending MEM request is chained straight after the fetch ack.
        if (bus_ack_i) begin
          if (mem_req_i) begin
            w_load_mem = 1'b1;
            w_next     = S_MEM_XFER;
          end else begin
            w_next = S_IDLE;
          end
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else if (flush_if_i) begin
          w_next = S_IF_DRAIN;
        end
      end
      S_MEM_XFER, S_IF_DRAIN: begin
        if (w_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_sel   <= 4'h0;
    end else begin
      r_state <= w_next;
      if (w_load_mem) begin
        r_we    <= mem_we_i;
        r_addr  <= mem_addr_i;
        r_wdata <= mem_wdata_i;
        r_sel   <= mem_sel_i;
      end else if (w_load_if) begin
        r_we   <= 1'b0;
        r_addr <= if_addr_i;
        r_sel  <= 4'hF;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  assign w_timeout = bus_req_o && !bus_ack_i && (r_wait_cnt == 8'(TIMEOUT_CYCLES));
  assign bus_err_o = w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 8'h0;
    end else if ((w_next != S_IDLE) && (w_next != r_state)) begin
      r_wait_cnt <= 8'h0;
    end else if (bus_req_o && !bus_ack_i) begin
      r_wait_cnt <= r_wait_cnt + 8'h1;
    end
  end
`else
  // Legal limits are nonzero, so this folds to a constant 0.
  assign w_timeout = (TIMEOUT_CYCLES == 0);
  assign bus_err_o = 1'b0;
`endif

  assign bus_req_o   = (r_state != S_IDLE);
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign bus_sel_o   = r_sel;

  // A flush in the ack cycle discards the fetch data and suppresses the ack.
  assign w_if_data  = (r_state == S_IF_XFER) && bus_ack_i && !flush_if_i;
  assign w_mem_data = (r_state == S_MEM_XFER) && bus_ack_i;

  assign if_ack_o    = w_if_data | ((r_state == S_IF_XFER) && w_timeout && !flush_if_i);
  assign if_rdata_o  = w_if_data ? bus_rdata_i : 32'h0;
  assign mem_ack_o   = (r_state == S_MEM_XFER) && w_done;
  assign mem_rdata_o = w_mem_data ? bus_rdata_i : 32'h0;

  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_bus_arb.sv
// tb/tb_bus_arb.sv - directed self-checking bench for bus_arb
module tb_bus_arb;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        stallreq_if_o;
  logic        flush_if_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .if_ack_o       (if_ack_o),
    .stallreq_if_o  (stallreq_if_o),
    .flush_if_i     (flush_if_i),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_sel_i      (mem_sel_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ack_o      (mem_ack_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_sel_o      (bus_sel_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i),
    .bus_err_o      (bus_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0; flush_if_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    mem_sel_i = 4'h0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
    #1;
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_we", bus_we_o, 0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_wdata", bus_wdata_o, 32'h0);
    chk("rst_bus_sel", bus_sel_o, 4'h0);
    chk("rst_if_ack", if_ack_o, 0);
    chk("rst_mem_ack", mem_ack_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_mem_rdata", mem_rdata_o, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // single fetch, zero-wait slave
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    #1;
    chk("f1_stall_req", stallreq_if_o, 1);
    chk("f1_bus_idle", bus_req_o, 0);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0013;
    #1;
    chk("f1_bus_req", bus_req_o, 1);
    chk("f1_bus_addr", bus_addr_o, 32'h100);
    chk("f1_bus_we", bus_we_o, 0);
    chk("f1_bus_sel", bus_sel_o, 4'hF);
    chk("f1_if_ack", if_ack_o, 1);
    chk("f1_if_rdata", if_rdata_o, 32'h13);
    chk("f1_stall_ack", stallreq_if_o, 0);
    chk("f1_mem_ack", mem_ack_o, 0);
    tick();
    if_req_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("f1_idle_req", bus_req_o, 0);
    chk("f1_idle_ack", if_ack_o, 0);
    chk("f1_idle_rdata", if_rdata_o, 32'h0);

    // simultaneous IF and MEM write: MEM first, one idle cycle, then IF
    if_req_i = 1'b1; if_addr_i = 32'h200;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8000_0000;
    mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'hF;
    tick();
    chk("s_bus_we", bus_we_o, 1);
    chk("s_bus_addr", bus_addr_o, 32'h8000_0000);
    chk("s_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    chk("s_stall_mem", stallreq_mem_o, 1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0;
    #1;
    chk("s_mem_ack", mem_ack_o, 1);
    chk("s_if_ack", if_ack_o, 0);
    chk("s_stall_mem_ack", stallreq_mem_o, 0);
    chk("s_stall_if", stallreq_if_o, 1);
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("s_idle_gap", bus_req_o, 0);
    tick();
    chk("s_if_req", bus_req_o, 1);
    chk("s_if_addr", bus_addr_o, 32'h200);
    chk("s_if_we", bus_we_o, 0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
    #1;
    chk("s_if_ack2", if_ack_o, 1);
    chk("s_if_rdata", if_rdata_o, 32'hCAFE_0001);
    tick();
    if_req_i = 1'b0; bus_ack_i = 1'b0;

    // IF with 3 wait cycles, MEM read arrives meanwhile, chained with no idle
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h4000; mem_sel_i = 4'h3;
    #1;
    chk("b_wait1_ack", if_ack_o, 0);
    chk("b_wait1_stall", stallreq_mem_o, 1);
    tick();
    chk("b_wait2_addr", bus_addr_o, 32'h300);
    tick();
    chk("b_wait3_addr", bus_addr_o, 32'h300);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    #1;
    chk("b_if_ack", if_ack_o, 1);
    chk("b_if_rdata", if_rdata_o, 32'h1111_1111);
    chk("b_mem_ack0", mem_ack_o, 0);
    tick();
    if_req_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("b_mem_req", bus_req_o, 1);
    chk("b_mem_addr", bus_addr_o, 32'h4000);
    chk("b_mem_sel", bus_sel_o, 4'h3);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_55AA;
    #1;
    chk("b_mem_ack", mem_ack_o, 1);
    chk("b_mem_rdata", mem_rdata_o, 32'h55AA);
    tick();
    mem_req_i = 1'b0; bus_ack_i = 1'b0;

    // flush during a fetch wait: drain, ack swallowed
    if_req_i = 1'b1; if_addr_i = 32'h500;
    tick();
    flush_if_i = 1'b1;
    #1;
    chk("fl_ack_flush", if_ack_o, 0);
    tick();
    flush_if_i = 1'b0; if_req_i = 1'b0;
    #1;
    chk("fl_drain_req", bus_req_o, 1);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h99;
    #1;
    chk("fl_drain_ack", if_ack_o, 0);
    chk("fl_drain_rdata", if_rdata_o, 32'h0);
    chk("fl_drain_req2", bus_req_o, 1);
    tick();
    bus_ack_i = 1'b0;
    #1;
    chk("fl_idle", bus_req_o, 0);

    // flush coinciding with the ack
    if_req_i = 1'b1; if_addr_i = 32'h600;
    tick();
    flush_if_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h77;
    #1;
    chk("fa_ack", if_ack_o, 0);
    chk("fa_rdata", if_rdata_o, 32'h0);
    tick();
    bus_ack_i = 1'b0;
    #1;
    chk("fa_idle", bus_req_o, 0);
    // flush held in IDLE blocks the fetch; stray slave ack in IDLE is ignored
    bus_ack_i = 1'b1;
    #1;
    chk("idle_ack_if", if_ack_o, 0);
    chk("idle_ack_mem", mem_ack_o, 0);
    tick();
    chk("fi_blocked", bus_req_o, 0);
    flush_if_i = 1'b0; if_req_i = 1'b0; bus_ack_i = 1'b0;
    tick();

    // asynchronous reset in the middle of a MEM transfer
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h700; mem_sel_i = 4'h1;
    tick();
    chk("r_mem_req", bus_req_o, 1);
    chk("r_mem_addr", bus_addr_o, 32'h700);
    #2;
    rst = 1'b0;
    #1;
    chk("r_async_req", bus_req_o, 0);
    chk("r_async_addr", bus_addr_o, 32'h0);
    chk("r_async_sel", bus_sel_o, 4'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234;
    #1;
    chk("r_no_ack", mem_ack_o, 0);
    chk("r_no_rdata", mem_rdata_o, 32'h0);
    tick();
    mem_req_i = 1'b0; bus_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("r_after", bus_req_o, 0);

`ifdef BUS_ARB_TIMEOUT_EN
    // slave never acks a MEM read; limit 4 terminates in the 5th active cycle
    mem_req_i = 1'b1; mem_addr_i = 32'h800; mem_sel_i = 4'hF; bus_rdata_i = 32'hBAD0_BAD0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_err_c%0d", i), bus_err_o, 0);
      chk($sformatf("to_ack_c%0d", i), mem_ack_o, 0);
    end
    tick();
    chk("to_err", bus_err_o, 1);
    chk("to_ack", mem_ack_o, 1);
    chk("to_rdata", mem_rdata_o, 32'h0);
    tick();
    mem_req_i = 1'b0;
    #1;
    chk("to_idle", bus_req_o, 0);
    chk("to_err_off", bus_err_o, 0);
`else
    // without the timeout the arbiter waits on the slave indefinitely
    mem_req_i = 1'b1; mem_addr_i = 32'h800; mem_sel_i = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("nt_err_c%0d", i), bus_err_o, 0);
      chk($sformatf("nt_ack_c%0d", i), mem_ack_o, 0);
    end
    chk("nt_still_busy", bus_req_o, 1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    #1;
    chk("nt_late_ack", mem_ack_o, 1);
    chk("nt_late_rdata", mem_rdata_o, 32'h0BAD_F00D);
    tick();
    mem_req_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("nt_idle", bus_req_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
